sar_track_adc_ctrl: RTL and testbench

//  Parametrised ADC conversion controller: drives the DAC code (count) and reads the

---
 rtl/adc_ctrl_pkg.sv | 29 ++
 rtl/sar_track_adc_ctrl_settle_timer.sv | 29 ++
 rtl/sar_track_adc_ctrl.sv | 155 +++++++++++++++
 tb/tb_sar_track_adc_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg: shared state, mode and comparator-decision types
// for the SAR / tracking ADC conversion controller.
package adc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_TSETTLE,
        ST_TSAMPLE
    } state_e;

    localparam logic MODE_TRACK = 1'b0;
    localparam logic MODE_SAR   = 1'b1;

    typedef enum logic [1:0] {
        DEC_HOLD,
        DEC_UP,
        DEC_DOWN
    } dec_e;

    // Both comparator outputs high is treated like neither: no move.
    function automatic dec_e decide(input logic up, input logic down);
        if (up && !down) return DEC_UP;
        if (down && !up) return DEC_DOWN;
        return DEC_HOLD;
    endfunction

endpackage

// File: rtl/sar_track_adc_ctrl_settle_timer.sv
// settle_timer: loadable down-counter that paces DAC settling.
// Loads SETTLE-1 so the wait state lasts exactly SETTLE clocks.
module settle_timer #(
    parameter int SETTLE = 4
) (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int TW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [TW-1:0] LOAD_V = TW'((SETTLE > 0) ? SETTLE - 1 : 0);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_V;
        end else if (dec && cnt_q != '0) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sar_track_adc_ctrl.sv
// sar_track_adc_ctrl: DAC-code controller for a comparator-based ADC,
// one-shot successive approximation or continuous +/-1 tracking.
module sar_track_adc_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 4,
    parameter int LOCK_N = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             mode,
    input  logic             start,
    input  logic             abort,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             locked
);
    localparam int BW = $clog2(WIDTH);
    localparam int LW = $clog2(LOCK_N + 1);
    localparam bit SETTLE_EN = (SETTLE > 0);
    localparam logic [WIDTH-1:0] CODE_MAX = '1;
    localparam logic [WIDTH-1:0] CODE_MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);
    localparam state_e SAR_WAIT = SETTLE_EN ? ST_SETTLE : ST_DECIDE;
    localparam state_e TRK_WAIT = SETTLE_EN ? ST_TSETTLE : ST_TSAMPLE;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [LW-1:0]    lock_q, lock_d;
    logic             t_load, t_dec, t_zero;
    logic [WIDTH-1:0] bit_mask;
    dec_e             dec;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clock (clock),
        .clear (clear),
        .load  (t_load),
        .dec   (t_dec),
        .zero  (t_zero)
    );

    assign dec      = decide(up, down);
    assign bit_mask = WIDTH'(1) << bit_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            bit_q    <= '0;
            lock_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
            bit_q    <= bit_d;
            lock_q   <= lock_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = 1'b0;
        bit_d    = bit_q;
        lock_d   = lock_q;
        t_load   = 1'b0;
        t_dec    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    t_load = 1'b1;
                    lock_d = '0;
                    if (mode == MODE_SAR) begin
                        count_d = CODE_MSB;
                        bit_d   = BIT_TOP;
                        state_d = SAR_WAIT;
                    end else begin
                        state_d = TRK_WAIT;
                    end
                end
            end
            ST_SETTLE, ST_TSETTLE: begin
                if (t_zero) begin
                    state_d = (state_q == ST_SETTLE) ? ST_DECIDE : ST_TSAMPLE;
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_DECIDE: begin
                if (dec == DEC_DOWN) count_d = count_q & ~bit_mask;
                if (bit_q != '0) begin
                    count_d = count_d | (bit_mask >> 1);
                    bit_d   = bit_q - BW'(1);
                    t_load  = 1'b1;
                    state_d = SAR_WAIT;
                end else begin
                    result_d = count_d;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_TSAMPLE: begin
                unique case (dec)
                    DEC_UP: begin
                        if (count_q != CODE_MAX) count_d = count_q + WIDTH'(1);
                        lock_d = '0;
                    end
                    DEC_DOWN: begin
                        if (count_q != '0) count_d = count_q - WIDTH'(1);
                        lock_d = '0;
                    end
                    default: begin
                        if (lock_q != LOCK_MAX) lock_d = lock_q + LW'(1);
                    end
                endcase
                result_d = count_d;
                done_d   = 1'b1;
                t_load   = 1'b1;
                state_d  = TRK_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort freezes the codes and drops the lock without a done strobe.
        if (abort && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            count_d  = count_q;
            result_d = result_q;
            done_d   = 1'b0;
            bit_d    = bit_q;
            lock_d   = '0;
            t_load   = 1'b0;
            t_dec    = 1'b0;
        end
    end

    assign count  = count_q;
    assign result = result_q;
    assign done   = done_q;
    assign busy   = (state_q != ST_IDLE);
    assign locked = (lock_q == LOCK_MAX);

endmodule

// File: tb/tb_sar_track_adc_ctrl.sv
// tb_sar_track_adc_ctrl: behavioural comparator/DAC loop around the
// controller, checked against an arithmetic model of SAR and tracking.
module tb_sar_track_adc_ctrl;
    localparam int W    = 8;
    localparam int ST   = 2;
    localparam int LN   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         clear, mode, start, abort, up, down;
    logic [W-1:0] count, result;
    logic         done, busy, locked;

    int analog   = 0;
    int cmp_mode = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int m_count  = 0;
    int m_lock   = 0;
    int last_res = 0;

    sar_track_adc_ctrl #(.WIDTH(W), .SETTLE(ST), .LOCK_N(LN)) dut (
        .clock  (clock),
        .clear  (clear),
        .mode   (mode),
        .start  (start),
        .abort  (abort),
        .up     (up),
        .down   (down),
        .count  (count),
        .result (result),
        .done   (done),
        .busy   (busy),
        .locked (locked)
    );

    always #5 clock = ~clock;

    // Comparator: 0 ideal, 1 both high, 2 stuck up, 3 stuck down.
    always_comb begin
        up   = 1'b0;
        down = 1'b0;
        if (cmp_mode == 1) begin
            up   = 1'b1;
            down = 1'b1;
        end else if (cmp_mode == 2) begin
            up = 1'b1;
        end else if (cmp_mode == 3) begin
            down = 1'b1;
        end else begin
            up   = analog > int'(count);
            down = analog < int'(count);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > MAXV) ? MAXV : v);
    endfunction

    task automatic run_sar(input int a, input bit chk_seq);
        int n, nbusy, code, trial, exp;
        logic [W-1:0] seq[$];
        int eseq[$];
        analog   = a;
        cmp_mode = 0;
        exp      = clamp(a);
        code     = 0;
        trial    = 0;
        for (int b = W - 1; b >= 0; b--) begin
            trial = code | (1 << b);
            eseq.push_back(trial);
            if (!(a < trial)) code = trial;
        end
        if (code != trial) eseq.push_back(code);
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n     = 1;
        nbusy = 0;
        seq.push_back(count);
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) nbusy++;
            if (count !== seq[$]) seq.push_back(count);
            tick();
            n++;
        end
        if (count !== seq[$]) seq.push_back(count);
        check("sar_latency", n, W * (ST + 1) + 1);
        check("sar_busy_cycles", nbusy, W * (ST + 1));
        check("sar_busy_end", busy, 0);
        check("sar_result", result, exp);
        check("sar_count", count, exp);
        if (chk_seq) begin
            check("sar_seq_len", seq.size(), eseq.size());
            for (int i = 0; i < seq.size() && i < eseq.size(); i++)
                check("sar_seq", seq[i], eseq[i]);
        end
        tick();
        check("sar_done_pulse", done, 0);
        m_count  = exp;
        m_lock   = 0;
        last_res = exp;
    endtask

    task automatic start_track();
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start  = 1'b0;
        mode   = 1'($urandom);
        m_lock = 0;
        check("trk_busy", busy, 1);
    endtask

    task automatic track_sample();
        int n, d;
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 10);
        check("trk_period", n, ST + 1);
        if (cmp_mode == 1) d = 0;
        else if (cmp_mode == 2) d = 1;
        else if (cmp_mode == 3) d = -1;
        else d = (analog > m_count) ? 1 : ((analog < m_count) ? -1 : 0);
        if (d == 0) begin
            if (m_lock < LN) m_lock++;
        end else begin
            m_lock  = 0;
            m_count = clamp(m_count + d);
        end
        last_res = m_count;
        check("trk_count", count, m_count);
        check("trk_result", result, m_count);
        check("trk_locked", locked, m_lock >= LN);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_locked", locked, 0);
        check("abort_done", done, 0);
        check("abort_count", count, m_count);
        check("abort_result", result, last_res);
        m_lock = 0;
    endtask

    initial begin
        int a, code, nd;
        clear = 1'b1;
        mode  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("rst_count", count, 0);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_locked", locked, 0);
        clear = 1'b0;
        tick();

        run_sar(8'h5A, 1'b1);
        run_sar(300, 1'b1);
        run_sar(0, 1'b1);
        for (int i = 0; i < 6; i++) run_sar($urandom_range(0, MAXV), 1'b1);

        run_sar(0, 1'b0);
        start_track();
        analog = 8'h10;
        repeat (16) track_sample();
        check("trk_reach", count, 8'h10);
        repeat (4) track_sample();
        check("trk_lock_up", locked, 1);
        analog = 8'h0C;
        track_sample();
        check("trk_lock_drop", locked, 0);
        repeat (3) track_sample();
        check("trk_reach2", count, 8'h0C);
        cmp_mode = 1;
        repeat (5) track_sample();
        cmp_mode = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                analog = m_count + int'($urandom_range(0, 6)) - 3;
            cmp_mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
            track_sample();
        end
        cmp_mode = 0;
        do_abort();

        run_sar(300, 1'b0);
        start_track();
        cmp_mode = 2;
        repeat (3) track_sample();
        do_abort();
        run_sar(0, 1'b0);
        start_track();
        cmp_mode = 3;
        repeat (3) track_sample();
        do_abort();
        cmp_mode = 0;

        a      = $urandom_range(0, MAXV);
        analog = a;
        code   = 0;
        for (int b = W - 1; b >= W - 4; b--)
            if (!(a < (code | (1 << b)))) code = code | (1 << b);
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 13; c++) begin
            tick();
            start = (c == 5);
            if (c == 5) mode = 1'b0;
        end
        start = 1'b0;
        check("ab_progress", count, code | (1 << (W - 5)));
        m_count = code | (1 << (W - 5));
        do_abort();
        nd = 0;
        repeat (30) begin
            tick();
            if (done === 1'b1) nd++;
        end
        check("ab_no_done", nd, 0);
        check("ab_count_hold", count, m_count);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("ab_beats_start", busy, 0);

        run_sar($urandom_range(1, MAXV), 1'b0);
        analog = $urandom_range(0, MAXV);
        mode   = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        clear = 1'b1;
        #1;
        check("clr_count", count, 0);
        check("clr_result", result, 0);
        check("clr_done", done, 0);
        check("clr_busy", busy, 0);
        check("clr_locked", locked, 0);
        tick();
        clear = 1'b0;
        tick();
        run_sar($urandom_range(0, MAXV), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
